// File: rtl/count_down_60.sv
// count_down_60: chainable, loadable mod-60 BCD down-counter.
// Built as a mod-10 ones stage and a mod-6 tens stage with borrow chaining.
// WRAP=1 wraps 00 -> 59, WRAP=0 saturates at 00.
// Optional sticky expiry flag: define COUNT_DOWN_60_DONE_EN to build the
// done register; otherwise done is tied low.
module count_down_60 #(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       bo,
    output logic       zero,
    output logic       load_err,
    output logic       done
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       load_err_q, load_err_d;
    logic       load_ok;
    logic       borrow_ot;
    logic       expire;

    // A preset is accepted only when both digits are legal BCD for a 00..59 count.
    assign load_ok   = (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);

    // Ones stage borrows into the tens stage when it is about to step below 0.
    assign borrow_ot = en & (ones_q == 4'd0) & ~load;

    assign zero      = (ones_q == 4'd0) && (tens_q == 4'd0);
    assign expire    = en & ~load & zero;
    assign bo        = expire & ~rst;

    assign count     = {tens_q, ones_q};
    assign load_err  = load_err_q;

    // Next-state for both digit stages; load wins over en on the same edge.
    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                tens_d = load_val[7:4];
                ones_d = load_val[3:0];
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            // Ones stage: mod-10 down; at 00 it only moves when the count wraps.
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else if ((tens_q != 4'd0) || WRAP) begin
                ones_d = 4'd9;
            end
            // Tens stage: mod-6 down, stepping only on the ones borrow.
            if (borrow_ot) begin
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else if (WRAP) begin
                    tens_d = 4'd5;
                end
            end
        end
    end

    // Count and load-error registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef COUNT_DOWN_60_DONE_EN
    logic done_q, done_d;

    // Sticky expiry: set when a decrement is requested at 00, cleared by any load.
    always_comb begin
        done_d = done_q;
        if (load) begin
            done_d = 1'b0;
        end else if (expire) begin
            done_d = 1'b1;
        end
    end

    // Expiry flag register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_count_down_60.sv
// Directed bench for count_down_60: wrapping instance, saturating instance
// and a seconds/minutes chain. Expected values go into a scoreboard queue
// when stimulus is applied and are popped when the outputs are sampled.
module tb_count_down_60;

`ifdef COUNT_DOWN_60_DONE_EN
    localparam logic DON = 1'b1;
`else
    localparam logic DON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic       en_a, load_a, bo_a, zero_a, lerr_a, done_a;
    logic [7:0] lv_a, cnt_a;
    logic       en_b, load_b, bo_b, zero_b, lerr_b, done_b;
    logic [7:0] lv_b, cnt_b;
    logic       en_s, load_s, bo_s, zero_s, lerr_s, done_s;
    logic [7:0] lv_s, cnt_s;
    logic       load_m, bo_m, zero_m, lerr_m, done_m;
    logic [7:0] lv_m, cnt_m;

    always #5 clk = ~clk;

    count_down_60 #(.WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .load(load_a), .load_val(lv_a),
        .count(cnt_a), .bo(bo_a), .zero(zero_a), .load_err(lerr_a), .done(done_a)
    );

    count_down_60 #(.WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .load(load_b), .load_val(lv_b),
        .count(cnt_b), .bo(bo_b), .zero(zero_b), .load_err(lerr_b), .done(done_b)
    );

    count_down_60 #(.WRAP(1'b1)) dut_sec (
        .clk(clk), .rst(rst), .en(en_s), .load(load_s), .load_val(lv_s),
        .count(cnt_s), .bo(bo_s), .zero(zero_s), .load_err(lerr_s), .done(done_s)
    );

    count_down_60 #(.WRAP(1'b1)) dut_min (
        .clk(clk), .rst(rst), .en(bo_s), .load(load_m), .load_val(lv_m),
        .count(cnt_m), .bo(bo_m), .zero(zero_m), .load_err(lerr_m), .done(done_m)
    );

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push_exp(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%02h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en_a = 0; load_a = 0; lv_a = 8'h00;
        en_b = 0; load_b = 0; lv_b = 8'h00;
        en_s = 0; load_s = 0; lv_s = 8'h00;
        load_m = 0; lv_m = 8'h00;
        #1;
        push_exp("reset_count", 8'h00); chk(cnt_a);
        push_exp("reset_lerr", 8'h00);  chk({7'd0, lerr_a});
        push_exp("reset_done", 8'h00);  chk({7'd0, done_a});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: async reset mid-cycle while counting from 37
        load_a = 1; lv_a = 8'h37;
        push_exp("t1_load37", 8'h37);
        tick(); chk(cnt_a);
        load_a = 0; en_a = 1;
        #3 rst = 1'b1;
        #1;
        push_exp("t1_rst_count", 8'h00); chk(cnt_a);
        push_exp("t1_rst_bo", 8'h00);    chk({7'd0, bo_a});
        push_exp("t1_rst_lerr", 8'h00);  chk({7'd0, lerr_a});
        for (int i = 0; i < 2; i++) begin
            push_exp("t1_rst_hold", 8'h00);
            tick(); chk(cnt_a);
        end
        rst = 1'b0; en_a = 0;

        // Test 2: load 42 then decrement across the tens borrow
        load_a = 1; lv_a = 8'h42;
        push_exp("t2_load42", 8'h42);
        tick(); chk(cnt_a);
        load_a = 0; en_a = 1;
        push_exp("t2_dec41", 8'h41); tick(); chk(cnt_a);
        push_exp("t2_dec40", 8'h40); tick(); chk(cnt_a);
        push_exp("t2_bo_nonzero", 8'h00); chk({7'd0, bo_a});
        push_exp("t2_dec39", 8'h39); tick(); chk(cnt_a);

        // Test 3: wrap through 00 on the WRAP=1 instance
        en_a = 0; load_a = 1; lv_a = 8'h01;
        push_exp("t3_load01", 8'h01);
        tick(); chk(cnt_a);
        load_a = 0; en_a = 1;
        push_exp("t3_dec00", 8'h00); tick(); chk(cnt_a);
        push_exp("t3_zero", 8'h01);  chk({7'd0, zero_a});
        push_exp("t3_bo", 8'h01);    chk({7'd0, bo_a});
        push_exp("t3_done_pre", 8'h00); chk({7'd0, done_a});
        push_exp("t3_wrap59", 8'h59); tick(); chk(cnt_a);
        push_exp("t3_done_set", {7'd0, DON}); chk({7'd0, done_a});
        push_exp("t3_dec58", 8'h58); tick(); chk(cnt_a);
        push_exp("t3_done_keep", {7'd0, DON}); chk({7'd0, done_a});
        en_a = 0;

        // Test 4: saturating instance holds at 00 with bo every cycle
        load_b = 1; lv_b = 8'h00;
        push_exp("t4_load00", 8'h00);
        tick(); chk(cnt_b);
        load_b = 0; en_b = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            push_exp("t4_bo", 8'h01); chk({7'd0, bo_b});
            push_exp("t4_hold00", 8'h00);
            tick(); chk(cnt_b);
            push_exp("t4_done", {7'd0, DON}); chk({7'd0, done_b});
        end
        en_b = 0;

        // Test 5: rejected loads hold the count and pulse load_err
        load_a = 1; lv_a = 8'h20;
        push_exp("t5_load20", 8'h20);
        tick(); chk(cnt_a);
        push_exp("t5_done_clr", 8'h00); chk({7'd0, done_a});
        lv_a = 8'h6A;
        push_exp("t5_6A_hold", 8'h20); tick(); chk(cnt_a);
        push_exp("t5_6A_lerr", 8'h01); chk({7'd0, lerr_a});
        lv_a = 8'h5A;
        push_exp("t5_5A_hold", 8'h20); tick(); chk(cnt_a);
        push_exp("t5_5A_lerr", 8'h01); chk({7'd0, lerr_a});
        lv_a = 8'h60;
        push_exp("t5_60_hold", 8'h20); tick(); chk(cnt_a);
        push_exp("t5_60_lerr", 8'h01); chk({7'd0, lerr_a});
        lv_a = 8'h55;
        push_exp("t5_load55", 8'h55); tick(); chk(cnt_a);
        push_exp("t5_55_lerr", 8'h00); chk({7'd0, lerr_a});
        load_a = 0;
        push_exp("t5_idle_hold", 8'h55); tick(); chk(cnt_a);

        // Test 6: seconds/minutes chain
        load_s = 1; lv_s = 8'h00; load_m = 1; lv_m = 8'h02;
        tick();
        push_exp("t6_sec_pre", 8'h00); chk(cnt_s);
        push_exp("t6_min_pre", 8'h02); chk(cnt_m);
        load_s = 0; load_m = 0; en_s = 1;
        tick();
        push_exp("t6_sec_first", 8'h59); chk(cnt_s);
        push_exp("t6_min_first", 8'h01); chk(cnt_m);
        repeat (60) @(posedge clk);
        #1;
        push_exp("t6_sec_60", 8'h59); chk(cnt_s);
        push_exp("t6_min_60", 8'h00); chk(cnt_m);
        load_s = 1; lv_s = 8'h15;
        #1;
        push_exp("t6_bo_load", 8'h00); chk({7'd0, bo_s});
        tick();
        push_exp("t6_sec_load15", 8'h15); chk(cnt_s);
        push_exp("t6_min_nochg", 8'h00); chk(cnt_m);
        load_s = 0; en_s = 0;

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_down_60.md
Name: count_down_60

Overview:
Chainable, loadable mod-60 BCD down-counter, the decrementing counterpart to the team's mod-60 up-counter. Used for countdown timers: seconds/minutes stages, with the upper stage's en driven by the lower stage's borrow. It is built internally as a ones stage (mod-10 down) and a tens stage (mod-6 down), with borrow chaining between them. It adds a synchronous preset load with BCD validity checking.

Parameters:
WRAP, 1, 1: 00 decrements to 59; 0: counter saturates at 00 and holds.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable / borrow-in; one decrement per clk edge while high
load  input  1  synchronous preset strobe
load_val  input  8  preset, packed BCD {tens[7:4], ones[3:0]}
count  output  8  current value, packed BCD {tens, ones}
bo  output  1  borrow out, combinational; drives next stage's en
zero  output  1  combinational, high when count == 8'h00
load_err  output  1  registered; one-cycle pulse on a rejected load
done  output  1  sticky expiry flag (see Optional Feature)

Behaviour:
- Reset (rst high, asynchronous): count=8'h00, load_err=0, done=0. bo is forced 0 while rst is high.
- Priority at each clk edge: rst > load > en.
- Load validity: load_val is valid iff tens<=5 and ones<=9.
- Valid load: count <= load_val on that edge; load_err <= 0. en is ignored on that edge.
- Invalid load: count holds; load_err <= 1 for exactly one cycle; en is ignored on that edge.
- Back-to-back invalid loads: load_err stays high for each cycle in which the prior edge saw an invalid load.
- Decrement (en=1, load=0):
  - ones!=0: ones-1, tens unchanged.
  - ones==0, tens!=0: ones=9, tens-1.
  - count==00, WRAP=1: count=8'h59.
  - count==00, WRAP=0: count holds 8'h00.
- Hold: en=0, load=0 leaves count unchanged.
- bo = en & (count==8'h00) & ~load & ~rst, independent of WRAP. It is high in the same cycle as the wrap/hold edge, not after it.
- Internal ones-to-tens borrow = en & (ones==0) & ~load. The tens stage decrements only on that borrow.
- Latency: count updates on the same edge as en/load; one-cycle latency to the output register.
- All count values stay within 00..59 BCD at all times. Illegal internal states are unreachable because load is gated by validity.
- Reset mid-count or mid-load: count goes to 00 immediately. No load or decrement is captured on an edge where rst is high.
- Chaining: stage N+1 en = stage N bo. Cascade values stay consistent because every bo is combinational from registered state.

Optional Feature:
Macro: COUNT_DOWN_60_DONE_EN
- Defined: done is a register.
  - Set on any edge where en=1, load=0 and count==8'h00 (expiry event).
  - Cleared by rst or by any load edge, valid or invalid.
  - Remains set across further decrements or wraps.
- Not defined: done is tied to constant 0; no flop is inferred.

Test Plan:
1. Assert rst async mid-cycle with count=8'h37, en=1 -> count=8'h00, bo=0, load_err=0 immediately. count stays 00 for 2 edges with rst held.
2. load=1, load_val=8'h42 -> count=8'h42. Then 3 edges with en=1 -> 41, 40, 39. The borrow into tens occurs at the 40->39 edge.
3. WRAP=1, load 8'h01, en=1 for 3 edges -> 00 (zero=1, bo=1 during this cycle), then 59, then 58. With the macro defined, done=1 from the 00->59 edge onward.
4. WRAP=0, count=8'h00, en=1 for 4 edges -> count stays 00, bo=1 every cycle. Macro defined: done=1 and persists.
5. load_val=8'h6A, then 8'h5A, then 8'h55 on successive edges, starting from count 8'h20 -> count holds 20 for two edges, load_err high the two cycles after, then count=8'h55 with load_err=0.
6. Two instances chained (minutes en = seconds bo), seconds preset 00, minutes preset 02, en=1 continuously -> seconds 59 / minutes 01 after first edge. After 60 more edges: seconds 59, minutes 00. load concurrent with en=1 on 8'h15 -> count=8'h15, no decrement.
